imem_boot_loader: RTL
=====================

# imem_boot_loader

Sequencing controller for the byte-addressed instruction memory. After reset it holds the core, accepts a program as a byte stream, and writes it into the memory. It then zero-fills every unwritten location and releases the core to fetch. It owns the memory's write port. It can reprogram the memory on command while the core is running.

## Interface
- DEPTH, 128, instruction memory size in bytes
- ADDR_W, 7, memory byte-address width; DEPTH == 2**ADDR_W
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- loadStart  in  1  single-cycle request to begin (re)programming
- loadValid  in  1  loadByte is valid this cycle
- loadByte  in  8  program byte; stream is little-endian, instruction byte 0 first
- loadLast  in  1  qualifies the final byte of the program; ignored unless loadValid
- loadReady  out  1  block accepts a byte this cycle
- memWe  out  1  memory byte-write enable
- memAddr  out  ADDR_W  memory byte address for the write
- memWdata  out  8  memory write data
- cpuHold  out  1  freeze PC/pipeline of the core
- loadDone  out  1  single-cycle pulse: memory image complete
- loadCount  out  ADDR_W+1  number of bytes accepted in the current/last load
- overflow  out  1  sticky: byte offered when none could be accepted

## Operation
- States: IDLE, LOAD, FILL, DONE, RUN. Internal wrPtr is ADDR_W+1 bits.
- IDLE (after reset):
  - cpuHold=1, loadReady=0.
  - loadStart goes to LOAD and clears wrPtr, loadCount and overflow.
- LOAD:
  - cpuHold=1, loadReady=1.
  - A byte is accepted when loadValid&loadReady. On acceptance: memWe=1, memAddr=wrPtr, memWdata=loadByte; wrPtr and loadCount increment.
  - Accepted byte with loadLast=1 and wrPtr+1<DEPTH goes to FILL.
  - Accepted byte with wrPtr==DEPTH-1 goes to DONE, whether or not loadLast is set.
- FILL:
  - memWe=1, memWdata=0, memAddr=wrPtr; wrPtr increments every cycle.
  - The write at DEPTH-1 goes to DONE.
- DONE:
  - Lasts one cycle. loadDone=1, cpuHold=1, then goes to RUN.
- RUN:
  - cpuHold=0, loadReady=0.
  - loadStart goes to LOAD, with the same clears as in IDLE.
- memWe/memAddr/memWdata are combinational from state, wrPtr and the load inputs. When memWe=0, memAddr=0 and memWdata=0.
- The memory commits a write on the clk edge that ends the cycle.
- overflow is set when loadValid=1 in FILL, DONE or RUN. It is never set in IDLE or LOAD.
- overflow is cleared only by reset or an accepted loadStart.
- loadStart is ignored in LOAD, FILL and DONE.
- loadValid is ignored in IDLE. No write occurs and overflow is not set.
- An accepted loadStart with loadValid in the same cycle: the byte is not accepted, because loadReady=0 in that cycle.

## Timing
- Reset values:
  - State IDLE, wrPtr=0, loadCount=0, overflow=0.
  - cpuHold=1, loadReady=0, memWe=0, memAddr=0, memWdata=0, loadDone=0.
- Reset asserted in any state, including mid-LOAD or mid-FILL, takes effect at the next edge. The memory contents left behind are undefined and must be reloaded.
- loadStart accepted at edge T: LOAD from T; loadReady=1 in the cycle after T.
- With N bytes streamed back-to-back (N<DEPTH, loadLast on byte N):
  - LOAD lasts N cycles, FILL lasts DEPTH-N cycles, DONE lasts 1 cycle.
  - cpuHold falls DEPTH+1 cycles after loadReady first rises.
- Full load (N==DEPTH): no FILL; DONE follows immediately after the last byte.
- Gaps in loadValid stall LOAD without any write. Addresses stay contiguous.
- Reprogram from RUN: cpuHold=1 in the cycle after loadStart is sampled.

## Test plan
- Basic load:
  - Stimulus: reset; loadStart; bytes 0x93,0x00,0x50,0x00,0x13,0x01,0xA0,0x00 back-to-back, loadLast on the 8th.
  - Required: writes to addr 0-7 with those bytes; zero writes to addr 8-127 over 120 cycles; loadDone one cycle; cpuHold=0 the next cycle; loadCount=8.
- Gapped stream:
  - Stimulus: loadValid toggled 1,0,0,1,0,1 over 3 bytes, loadLast on the 3rd.
  - Required: exactly 3 writes at addr 0,1,2; no writes on idle cycles; FILL covers addr 3-127.
- Full memory:
  - Stimulus: 128 bytes of 0xAA, no loadLast.
  - Required: DONE directly after the write at addr 127; no FILL; loadCount=128.
  - Stimulus: a 129th loadValid in RUN. Required: overflow=1, no write.
- Reprogram:
  - Stimulus: in RUN with overflow=1, pulse loadStart.
  - Required: cpuHold=1, overflow=0, loadCount=0 the next cycle; the following byte writes addr 0.
- Reset mid-FILL:
  - Stimulus: assert reset while memAddr=50 in FILL.
  - Required: next cycle IDLE; memWe=0, cpuHold=1, loadCount=0, loadDone never pulses.
- Ignored inputs:
  - Stimulus: loadValid=1 in IDLE, then loadStart during LOAD.
  - Required: no write and overflow=0 from the IDLE byte; the LOAD state, wrPtr and loadCount are unchanged by the extra loadStart.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// ----------------
// Sequencing controller for the byte-addressed instruction memory. After
// reset it holds the core, takes a program as a little-endian byte stream,
// writes it into memory, zero-fills every location the program did not
// reach, then releases the core. A loadStart while the core runs starts a
// fresh reprogramming pass.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   loadStart        single-cycle request to begin (re)programming
//   loadValid        loadByte is valid this cycle
//   loadByte         program byte, instruction byte 0 first
//   loadLast         marks the final program byte (only with loadValid)
//   loadReady        a byte is accepted this cycle when loadValid is high
//   memWe            memory byte-write enable
//   memAddr          memory byte address (0 when memWe is low)
//   memWdata         memory write data (0 when memWe is low)
//   cpuHold          freezes the core's PC/pipeline
//   loadDone         single-cycle pulse: memory image complete
//   loadCount        bytes accepted in the current/last load
//   overflow         sticky: a byte was offered when none could be taken
//
// Handshake: a byte transfers on a rising edge where loadValid and
// loadReady are both high. loadReady does not depend on loadValid, and a
// byte offered while loadReady is low is never taken.
module imem_boot_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadStart,
  input  logic              loadValid,
  input  logic [7:0]        loadByte,
  input  logic              loadLast,
  output logic              loadReady,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWdata,
  output logic              cpuHold,
  output logic              loadDone,
  output logic [ADDR_W:0]   loadCount,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FILL = 3'd2,
    S_DONE = 3'd3,
    S_RUN  = 3'd4
  } state_e;

  localparam logic [ADDR_W:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] load_count_q, load_count_d;
  logic            overflow_q, overflow_d;
  logic            at_last_addr;

  assign at_last_addr = (wr_ptr_q == LAST_ADDR);
  assign loadCount    = load_count_q;
  assign overflow     = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    loadReady    = 1'b0;
    memWe        = 1'b0;
    memAddr      = '0;
    memWdata     = '0;
    cpuHold      = 1'b1;
    loadDone     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Bytes offered here are dropped silently: no write, no overflow.
        if (loadStart) begin
          state_d      = S_LOAD;
          wr_ptr_d     = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end
      end

      S_LOAD: begin
        loadReady = 1'b1;
        if (loadValid) begin
          memWe        = 1'b1;
          memAddr      = wr_ptr_q[ADDR_W-1:0];
          memWdata     = loadByte;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          load_count_d = load_count_q + PTR_ONE;
          // Filling the top byte completes the image whatever loadLast says.
          if (at_last_addr) begin
            state_d = S_DONE;
          end else if (loadLast) begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        memWe    = 1'b1;
        memAddr  = wr_ptr_q[ADDR_W-1:0];
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (at_last_addr) begin
          state_d = S_DONE;
        end
        if (loadValid) begin
          overflow_d = 1'b1;
        end
      end

      S_DONE: begin
        loadDone = 1'b1;
        state_d  = S_RUN;
        if (loadValid) begin
          overflow_d = 1'b1;
        end
      end

      S_RUN: begin
        cpuHold = 1'b0;
        if (loadValid) begin
          overflow_d = 1'b1;
        end
        // A new load starts clean, so its clear wins over a same-cycle byte.
        if (loadStart) begin
          state_d      = S_LOAD;
          wr_ptr_d     = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
